// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MIPS multiply/divide unit with HI/LO registers
// Optional signed MULT/DIV support is built when MULDIV_SIGNED_EN is defined.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  state_t               state_q, state_d;
  logic [5:0]           cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic                 is_div_q, is_div_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 busy_q, done_q;

  logic                 accept_muldiv;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH+1:0]     div_trial;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  assign accept_muldiv = start && (state_q == IDLE || state_q == DONE) && !op[1];

  // Multiply keeps the multiplier in the low half and shifts the running sum down;
  // divide keeps {remainder, dividend} and shifts quotient bits in from the bottom.
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q & {WIDTH{acc_q[0]}}};
  assign div_trial = {1'b0, acc_q[2*WIDTH-2:WIDTH-1]} - {2'b00, opb_q};

`ifdef MULDIV_SIGNED_EN
  logic a_neg, b_neg, neg_q, rem_neg_q;

  assign a_neg = is_signed & rs_val[WIDTH-1];
  assign b_neg = is_signed & rt_val[WIDTH-1];
  assign a_mag = a_neg ? -rs_val : rs_val;
  assign b_mag = b_neg ? -rt_val : rt_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
    end else if (accept_muldiv) begin
      neg_q     <= a_neg ^ b_neg;
      rem_neg_q <= a_neg;
    end
  end

  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`else
  logic unused_is_signed;

  assign unused_is_signed = is_signed;
  assign a_mag    = rs_val;
  assign b_mag    = rt_val;
  assign prod_fix = acc_q;
  assign quo_fix  = acc_q[WIDTH-1:0];
  assign rem_fix  = acc_q[2*WIDTH-1:WIDTH];
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          case (op)
            OP_MTHI: hi_d = rs_val;
            OP_MTLO: lo_d = rs_val;
            OP_MUL: begin
              acc_d    = {{WIDTH{1'b0}}, b_mag};
              opb_d    = a_mag;
              is_div_d = 1'b0;
              cnt_d    = 6'd0;
              state_d  = CALC;
            end
            default: begin
              acc_d    = {{WIDTH{1'b0}}, a_mag};
              opb_d    = b_mag;
              is_div_d = 1'b1;
              cnt_d    = 6'd0;
              state_d  = CALC;
            end
          endcase
        end
      end
      CALC: begin
        if (cnt_q == 6'(WIDTH)) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + 6'd1;
          if (!is_div_q) begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          end else if (!div_trial[WIDTH+1]) begin
            acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
          end
        end
      end
      FIX: begin
        state_d = DONE;
        if (is_div_q) begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= (state_d == CALC) || (state_d == FIX);
      done_q   <= (state_d == DONE);
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed scoreboard bench for muldiv_unit
// Signed expectations apply when MULDIV_SIGNED_EN is defined.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic         is_signed;
  logic [W-1:0] rs_val, rt_val;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  typedef struct {
    string      tag;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   poke_en  = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .is_signed(is_signed),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drives start from the current point; returns #1 after the accepting edge.
  task automatic launch(input logic [1:0] o, input logic s, input logic [W-1:0] a,
                        input logic [W-1:0] b, input string tag,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input bit push);
    exp_t e;
    if (push) begin
      e.tag = tag; e.hi = eh; e.lo = el;
      sb.push_back(e);
    end
    start = 1'b1; op = o; is_signed = s; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    start = 1'b0;
    rs_val = $urandom; rt_val = $urandom;
  endtask

  // Waits for done; returns #1 after the edge that raised it (the DONE cycle).
  task automatic wait_result();
    exp_t e;
    int k;
    logic [W-1:0] hi_prev;
    bit got = 0;
    hi_prev = '0;
    for (k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        chk("busy_after_accept", busy, 1);
        chk("done_low_after_accept", done, 0);
      end
      if (poke_en && k == 10) begin
        hi_prev = hi;
        start = 1'b1; op = 2'b10; rs_val = 32'hDEADBEEF;
      end
      if (poke_en && k == 11) begin
        start = 1'b0;
        chk("ignored_start_hi", hi, hi_prev);
        chk("ignored_start_busy", busy, 1);
      end
      if (k == 33) chk("busy_in_fix", busy, 1);
      if (done) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      chk("done_timeout", 0, 1);
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      chk("latency", k, 34);
      chk("busy_low_in_done", busy, 0);
      if (sb.size() == 0) begin
        chk("scoreboard_empty", 0, 1);
      end else begin
        e = sb.pop_front();
        chk({e.tag, "_hi"}, hi, e.hi);
        chk({e.tag, "_lo"}, lo, e.lo);
      end
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic s, input logic [W-1:0] a,
                        input logic [W-1:0] b, input string tag,
                        input logic [W-1:0] eh, input logic [W-1:0] el);
    launch(o, s, a, b, tag, eh, el, 1);
    wait_result();
    @(posedge clk); #1;
    chk({tag, "_done_once"}, done, 0);
  endtask

  initial begin
    logic [63:0]  p;
    logic [W-1:0] ra, rb;

    rst_n = 1'b0; start = 1'b0; op = 2'b00; is_signed = 1'b0;
    rs_val = '0; rt_val = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // MTHI then MTLO on consecutive edges
    start = 1'b1; op = 2'b10; rs_val = 32'h12345678;
    @(posedge clk); #1;
    chk("mthi_hi", hi, 32'h12345678);
    chk("mthi_busy", busy, 0);
    chk("mthi_done", done, 0);
    op = 2'b11; rs_val = 32'hCAFEF00D;
    @(posedge clk); #1;
    start = 1'b0;
    chk("mtlo_lo", lo, 32'hCAFEF00D);
    chk("mtlo_hi_kept", hi, 32'h12345678);
    chk("mtlo_busy", busy, 0);
    chk("mtlo_done", done, 0);

    // Abort a multiply mid-CALC with reset
    @(posedge clk); #1;
    launch(2'b00, 1'b0, 32'd3, 32'd5, "abort", '0, '0, 0);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) chk("abort_no_done", done, 0);
    end

    @(posedge clk); #1;
    run_op(2'b00, 1'b0, 32'd3, 32'd5, "multu_3x5", 32'd0, 32'd15);
    run_op(2'b00, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max", 32'hFFFFFFFE, 32'h00000001);
    run_op(2'b01, 1'b0, 32'd100, 32'd7, "divu_100_7", 32'd2, 32'd14);
    run_op(2'b01, 1'b0, 32'd9, 32'd0, "divu_9_0", 32'd9, 32'hFFFFFFFF);

`ifdef MULDIV_SIGNED_EN
    run_op(2'b00, 1'b1, -32'sd6, 32'sd7, "mult_m6x7", 32'hFFFFFFFF, 32'hFFFFFFD6);
    run_op(2'b01, 1'b1, -32'sd7, 32'sd2, "div_m7_2", 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op(2'b01, 1'b1, 32'h80000000, 32'hFFFFFFFF, "div_ovf", 32'h0, 32'h80000000);
    run_op(2'b01, 1'b1, -32'sd9, 32'd0, "div_m9_0", 32'hFFFFFFF7, 32'h00000001);
    run_op(2'b00, 1'b0, -32'sd6, 32'sd7, "multu_m6x7", 32'h6, 32'hFFFFFFD6);
`else
    run_op(2'b00, 1'b1, -32'sd6, 32'sd7, "mult_m6x7", 32'h6, 32'hFFFFFFD6);
    run_op(2'b01, 1'b1, -32'sd7, 32'sd2, "div_m7_2", 32'h1, 32'h7FFFFFFC);
    run_op(2'b01, 1'b1, 32'h80000000, 32'hFFFFFFFF, "div_ovf", 32'h80000000, 32'h0);
    run_op(2'b01, 1'b1, -32'sd9, 32'd0, "div_m9_0", 32'hFFFFFFF7, 32'hFFFFFFFF);
`endif

    for (int i = 0; i < 3; i++) begin
      ra = $urandom; rb = $urandom;
      p = 64'(ra) * 64'(rb);
      run_op(2'b00, 1'b0, ra, rb, "multu_rand", p[63:32], p[31:0]);
      rb = rb >> (i * 12);
      if (rb == 0) run_op(2'b01, 1'b0, ra, rb, "divu_rand", ra, 32'hFFFFFFFF);
      else         run_op(2'b01, 1'b0, ra, rb, "divu_rand", ra % rb, ra / rb);
    end

    // start pulsed mid-CALC must be ignored
    poke_en = 1;
    launch(2'b00, 1'b0, 32'd1000, 32'd1000, "poke_mul", 32'd0, 32'd1000000, 1);
    wait_result();
    poke_en = 0;
    @(posedge clk); #1;

    // start held in the DONE cycle chains straight into the next operation
    launch(2'b01, 1'b0, 32'd50, 32'd6, "chain_a", 32'd2, 32'd8, 1);
    wait_result();
    chk("chain_done_cycle", done, 1);
    launch(2'b00, 1'b0, 32'h10000, 32'h10000, "chain_b", 32'd1, 32'd0, 1);
    wait_result();
    @(posedge clk); #1;
    chk("chain_done_once", done, 0);
    chk("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
